// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings and the queue entry layout.
// Pure declarations, no logic.
// Used by mem_stage_mo and ms_load_align.
package mem_pkg;

  // es_mem_op encodings
  localparam logic [2:0] OP_LW    = 3'd0;
  localparam logic [2:0] OP_LB    = 3'd1;
  localparam logic [2:0] OP_LBU   = 3'd2;
  localparam logic [2:0] OP_LH    = 3'd3;
  localparam logic [2:0] OP_LHU   = 3'd4;
  localparam logic [2:0] OP_LWL   = 3'd5;
  localparam logic [2:0] OP_LWR   = 3'd6;
  localparam logic [2:0] OP_STORE = 3'd7;

  // One in-flight instruction held by the MEM stage
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        is_mem;
    logic [2:0]  op;
    logic        ready;
    logic [31:0] alu_result;
    logic [31:0] rt_value;
    logic [31:0] result;
  } entry_t;

endpackage

// File: rtl/ms_load_align.sv
// Load data alignment: picks/extends bytes and halfwords, merges LWL/LWR with rt.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is captured.
module ms_load_align
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/halfword and build the op-specific result
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    case (op)
      OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: result = {24'h0, byte_sel};
      OP_LH:  result = {{16{half_sel[15]}}, half_sel};
      OP_LHU: result = {16'h0, half_sel};
      OP_LWL: begin
        // low (a+1) bytes of rdata land in the top of the register
        case (addr_lo)
          2'd0:    result = {rdata[7:0],  rt_value[23:0]};
          2'd1:    result = {rdata[15:0], rt_value[15:0]};
          2'd2:    result = {rdata[23:0], rt_value[7:0]};
          default: result = rdata;
        endcase
      end
      OP_LWR: begin
        // high (4-a) bytes of rdata land in the bottom of the register
        case (addr_lo)
          2'd0:    result = rdata;
          2'd1:    result = {rt_value[31:24], rdata[31:8]};
          2'd2:    result = {rt_value[31:16], rdata[31:16]};
          default: result = {rt_value[31:8],  rdata[31:24]};
        endcase
      end
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_mo.sv
// MEM stage with multiple outstanding data requests, completed in order from a circular queue.
// Non-mem instruction: 1 cycle to ms_to_ws_valid; loads/stores wait for their data_ok.
// ms_allowin drops only when the queue is full; a same-cycle dequeue does not free a slot.
module mem_stage_mo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            es_to_ms_valid,
  output logic            ms_allowin,
  input  logic            es_is_mem,
  input  logic [2:0]      es_mem_op,
  input  logic            es_gr_we,
  input  logic [4:0]      es_dest,
  input  logic [XLEN-1:0] es_pc,
  input  logic [XLEN-1:0] es_alu_result,
  input  logic [XLEN-1:0] es_rt_value,
  input  logic            data_sram_data_ok,
  input  logic [XLEN-1:0] data_sram_rdata,
  input  logic            flush,
  input  logic            ws_allowin,
  output logic            ms_to_ws_valid,
  output logic            ms_gr_we,
  output logic [4:0]      ms_dest,
  output logic [XLEN-1:0] ms_pc,
  output logic [XLEN-1:0] ms_result,
  output logic            ms_fwd_valid,
  output logic [4:0]      ms_fwd_dest,
  output logic [XLEN-1:0] ms_fwd_result,
  output logic            ms_fwd_stall,
  output logic            ms_resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        q_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, disc_q, disc_d;
  logic          err_q, err_d;

  logic          head_vld, enq, deq;
  entry_t        head_e, new_e;
  logic [CW-1:0] owed_cnt;
  logic          cpl_found;
  logic [PW-1:0] cpl_idx, scan_idx;
  logic          rsp_cpl;
  logic [CW:0]   disc_total;
  logic [31:0]   align_result;

  assign head_e     = q_q[head_q];
  assign head_vld   = (count_q != '0);
  assign ms_allowin = (count_q != CW'(DEPTH));
  assign enq        = es_to_ms_valid && ms_allowin && !flush;
  assign deq        = ms_to_ws_valid && ws_allowin;
  assign rsp_cpl    = data_sram_data_ok && (disc_q == '0) && cpl_found && !flush;

  assign ms_to_ws_valid = head_vld && head_e.ready;
  assign ms_gr_we       = head_vld && head_e.gr_we;
  assign ms_dest        = head_vld ? head_e.dest   : 5'd0;
  assign ms_pc          = head_vld ? head_e.pc     : '0;
  assign ms_result      = head_vld ? head_e.result : '0;
  assign ms_resp_err    = err_q;

  // Incoming entry; non-mem instructions are complete on arrival
  always_comb begin
    new_e            = '0;
    new_e.pc         = es_pc;
    new_e.dest       = es_dest;
    new_e.gr_we      = es_gr_we;
    new_e.is_mem     = es_is_mem;
    new_e.op         = es_mem_op;
    new_e.ready      = !es_is_mem;
    new_e.alu_result = es_alu_result;
    new_e.rt_value   = es_rt_value;
    new_e.result     = es_alu_result;
  end

  // Walk oldest to youngest: count owed responses, find the oldest owed entry, pick forward source
  always_comb begin
    owed_cnt      = '0;
    cpl_found     = 1'b0;
    cpl_idx       = '0;
    scan_idx      = '0;
    ms_fwd_valid  = 1'b0;
    ms_fwd_dest   = 5'd0;
    ms_fwd_result = '0;
    ms_fwd_stall  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (q_q[scan_idx].is_mem && !q_q[scan_idx].ready) begin
          owed_cnt = owed_cnt + 1'b1;
          if (!cpl_found) begin
            cpl_found = 1'b1;
            cpl_idx   = scan_idx;
          end
        end
        if (q_q[scan_idx].gr_we) begin
          // later (younger) matches overwrite older ones
          ms_fwd_stall = !q_q[scan_idx].ready;
          if (q_q[scan_idx].ready) begin
            ms_fwd_valid  = 1'b1;
            ms_fwd_dest   = q_q[scan_idx].dest;
            ms_fwd_result = q_q[scan_idx].result;
          end
        end
      end
    end
  end

  ms_load_align u_align (
    .op       (q_q[cpl_idx].op),
    .addr_lo  (q_q[cpl_idx].alu_result[1:0]),
    .rdata    (data_sram_rdata),
    .rt_value (q_q[cpl_idx].rt_value),
    .result   (align_result)
  );

  // Next-state for pointers, occupancy, discard counter and the error flag
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    disc_d     = disc_q;
    err_d      = err_q;
    disc_total = {1'b0, disc_q} + {1'b0, owed_cnt};
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // a response arriving in the flush cycle is already accounted for
      if (data_sram_data_ok) begin
        if (disc_total == '0) err_d = 1'b1;
        else                  disc_total = disc_total - 1'b1;
      end
      disc_d = disc_total[CW] ? '1 : disc_total[CW-1:0];
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (data_sram_data_ok) begin
        if (disc_q != '0)    disc_d = disc_q - 1'b1;
        else if (!cpl_found) err_d  = 1'b1;
      end
    end
  end

  // Control state register; reset drops any owed responses without discarding
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      disc_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      disc_q  <= disc_d;
      err_q   <= err_d;
    end
  end

  // Entry storage: write new entries at tail, complete the oldest owed entry on data_ok
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enq) q_q[tail_q] <= new_e;
      if (rsp_cpl) begin
        q_q[cpl_idx].ready  <= 1'b1;
        q_q[cpl_idx].result <= (q_q[cpl_idx].op == OP_STORE) ? q_q[cpl_idx].alu_result
                                                             : align_result;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_mo.sv
// Bench for mem_stage_mo: reference queue model plus directed scenarios.
// Inputs driven 1 time unit after the rising edge, outputs checked on the falling edge.
// Expected entries are pushed when an instruction is accepted and retired against the DUT head.
module tb_mem_stage_mo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic        es_is_mem;
  logic [2:0]  es_mem_op;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_pc, es_alu_result, es_rt_value;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        ws_allowin;
  logic        ms_to_ws_valid, ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_pc, ms_result;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_result;
  logic        ms_fwd_stall, ms_resp_err;

  mem_stage_mo #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_is_mem(es_is_mem), .es_mem_op(es_mem_op), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_rt_value(es_rt_value),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .flush(flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_pc(ms_pc), .ms_result(ms_result),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_result(ms_fwd_result),
    .ms_fwd_stall(ms_fwd_stall), .ms_resp_err(ms_resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        is_mem;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] result;
    logic        ready;
  } m_t;

  m_t          mq[$];
  int          mdisc = 0;
  bit          merr  = 0;
  bit          known = 0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] pc_ctr = 32'hBFC0_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference alignment written with shifts and masks
  function automatic logic [31:0] m_align(input logic [2:0] op, input logic [31:0] addr,
                                          input logic [31:0] rd, input logic [31:0] rt);
    int          a;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ones;
    a    = int'(addr[1:0]);
    ones = 32'hFFFF_FFFF;
    b    = 8'(rd >> (8 * a));
    h    = (a >= 2) ? rd[31:16] : rd[15:0];
    case (op)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'h0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'h0, h};
      3'd5:    return (rd << (8 * (3 - a))) | (rt & (ones >> (8 * (a + 1))));
      3'd6:    return (rd >> (8 * a)) | (rt & ~(ones >> (8 * a)));
      3'd7:    return addr;
      default: return rd;
    endcase
  endfunction

  task automatic check_outputs();
    logic        fv, st;
    logic [4:0]  fd;
    logic [31:0] fr;
    if (!known) return;
    fv = 0; st = 0; fd = 0; fr = 0;
    foreach (mq[i]) begin
      if (mq[i].gr_we) begin
        st = !mq[i].ready;
        if (mq[i].ready) begin fv = 1; fd = mq[i].dest; fr = mq[i].result; end
      end
    end
    chk("allowin", ms_allowin, mq.size() < DEPTH);
    chk("ws_valid", ms_to_ws_valid, (mq.size() > 0) && mq[0].ready);
    if (mq.size() > 0) begin
      chk("head_pc", ms_pc, mq[0].pc);
      chk("head_result", ms_result, mq[0].result);
      chk("head_dest", ms_dest, mq[0].dest);
      chk("head_gr_we", ms_gr_we, mq[0].gr_we);
    end else begin
      chk("idle_pc", ms_pc, 0);
      chk("idle_result", ms_result, 0);
      chk("idle_gr_we", ms_gr_we, 0);
    end
    chk("fwd_valid", ms_fwd_valid, fv);
    chk("fwd_dest", ms_fwd_dest, fd);
    chk("fwd_result", ms_fwd_result, fr);
    chk("fwd_stall", ms_fwd_stall, st);
    chk("resp_err", ms_resp_err, merr);
    chk("discard", dut.disc_q, mdisc);
  endtask

  task automatic model_update();
    bit enq, deq, found;
    int owed, k;
    m_t e;
    if (reset) begin
      mq.delete(); mdisc = 0; merr = 0; known = 1;
      return;
    end
    enq = es_to_ms_valid && (mq.size() < DEPTH) && !flush;
    deq = (mq.size() > 0) && mq[0].ready && ws_allowin;
    if (flush) begin
      owed = mdisc;
      foreach (mq[i]) if (mq[i].is_mem && !mq[i].ready) owed++;
      if (data_sram_data_ok) begin
        if (owed == 0) merr = 1;
        else owed--;
      end
      mdisc = owed;
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (data_sram_data_ok) begin
        if (mdisc > 0) mdisc--;
        else begin
          found = 0; k = 0;
          foreach (mq[i]) if (!found && mq[i].is_mem && !mq[i].ready) begin found = 1; k = i; end
          if (found) begin
            e = mq[k];
            e.ready  = 1;
            e.result = m_align(e.op, e.alu, data_sram_rdata, e.rt);
            mq[k] = e;
          end else merr = 1;
        end
      end
      if (enq) begin
        e.pc = es_pc; e.dest = es_dest; e.gr_we = es_gr_we; e.is_mem = es_is_mem;
        e.op = es_mem_op; e.alu = es_alu_result; e.rt = es_rt_value;
        e.result = es_alu_result; e.ready = !es_is_mem;
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic is_mem, input logic [2:0] op, input logic gr_we,
                           input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] rt);
    es_to_ms_valid = 1; es_is_mem = is_mem; es_mem_op = op; es_gr_we = gr_we;
    es_dest = dest; es_alu_result = alu; es_rt_value = rt; es_pc = pc_ctr;
    pc_ctr = pc_ctr + 4;
  endtask

  task automatic issue(input logic is_mem, input logic [2:0] op, input logic gr_we,
                       input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] rt);
    set_instr(is_mem, op, gr_we, dest, alu, rt);
    tick();
    es_to_ms_valid = 0;
  endtask

  task automatic resp(input logic [31:0] rd);
    data_sram_data_ok = 1; data_sram_rdata = rd;
    tick();
    data_sram_data_ok = 0;
  endtask

  // Single load held at the head so its aligned result can be compared to a constant
  task automatic one_load(input string tag, input logic [2:0] op, input logic [31:0] alu,
                          input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] expv);
    ws_allowin = 0;
    issue(1, op, op != 3'd7, 5'd9, alu, rt);
    resp(rd);
    chk(tag, ms_result, expv);
    ws_allowin = 1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; es_to_ms_valid = 0; es_is_mem = 0; es_mem_op = 0; es_gr_we = 0; es_dest = 0;
    es_pc = 0; es_alu_result = 0; es_rt_value = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    flush = 0; ws_allowin = 1;
    repeat (2) tick();
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_err", ms_resp_err, 0);
    reset = 0;

    // ALU op: visible to WB one cycle after acceptance
    issue(0, 3'd0, 1, 5'd3, 32'h0000_1234, 32'h0);
    chk("alu_latency", ms_to_ws_valid, 1);
    tick();

    // LB pending: forwarding must stall until data arrives
    ws_allowin = 0;
    issue(1, 3'd1, 1, 5'd4, 32'h0000_1003, 32'h0);
    chk("lb_stall", ms_fwd_stall, 1);
    resp(32'h80FF_1234);
    chk("lb_sext", ms_result, 32'hFFFF_FF80);
    ws_allowin = 1;
    tick();

    one_load("lbu", 3'd2, 32'h0000_1003, 32'h0,         32'h80FF_1234, 32'h0000_0080);
    one_load("lwl", 3'd5, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
    one_load("lwr", 3'd6, 32'h0000_2002, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);
    one_load("lh",  3'd3, 32'h0000_3002, 32'h0,         32'h8001_1234, 32'hFFFF_8001);
    one_load("lhu", 3'd4, 32'h0000_3000, 32'h0,         32'h1234_F00F, 32'h0000_F00F);
    one_load("lw",  3'd0, 32'h0000_3004, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF);
    one_load("sw",  3'd7, 32'h0000_4008, 32'h5555_5555, 32'h0BAD_0BAD, 32'h0000_4008);

    // data_ok in the same cycle as a new load completes the older one
    issue(1, 3'd0, 1, 5'd5, 32'h100, 32'h0);
    set_instr(1, 3'd0, 1, 5'd6, 32'h104, 32'h0);
    data_sram_data_ok = 1; data_sram_rdata = 32'h0000_00A1;
    tick();
    es_to_ms_valid = 0; data_sram_data_ok = 0;
    chk("enq_cycle_stall", ms_fwd_stall, 1);
    resp(32'h0000_00A2);
    repeat (2) tick();

    // Fill to DEPTH, offer a fifth, then retire in order
    for (int i = 0; i < DEPTH; i++) issue(1, 3'(i % 5), 1, 5'(10 + i), 32'h200 + 32'(i), 32'h7777_7777);
    chk("full_allowin", ms_allowin, 0);
    issue(0, 3'd0, 1, 5'd20, 32'h0000_0BAD, 32'h0);
    for (int i = 0; i < DEPTH; i++) resp(32'hC0DE_0000 + 32'(i * 32'h0101_0101));
    repeat (2) tick();

    // Flush with three owed responses: they are discarded, the fourth goes to the new load
    for (int i = 0; i < 3; i++) issue(1, 3'd0, 1, 5'(21 + i), 32'h300 + 32'(4 * i), 32'h0);
    flush = 1; tick(); flush = 0;
    chk("flush3_disc", dut.disc_q, 3);
    issue(1, 3'd0, 1, 5'd25, 32'h400, 32'h0);
    for (int i = 0; i < 3; i++) resp(32'hEEEE_0000 + 32'(i));
    chk("flush3_still_owed", ms_fwd_stall, 1);
    resp(32'h1357_9BDF);
    chk("flush3_new_load", ms_result, 32'h1357_9BDF);
    repeat (2) tick();

    // Flush coinciding with data_ok and an offered instruction, two owed
    for (int i = 0; i < 2; i++) issue(1, 3'd0, 1, 5'(26 + i), 32'h500 + 32'(4 * i), 32'h0);
    set_instr(0, 3'd0, 1, 5'd28, 32'h0000_0666, 32'h0);
    flush = 1; data_sram_data_ok = 1; data_sram_rdata = 32'h1;
    tick();
    flush = 0; data_sram_data_ok = 0; es_to_ms_valid = 0;
    chk("flushco_disc", dut.disc_q, 1);
    chk("flushco_no_enq", ms_to_ws_valid, 0);
    resp(32'h2);
    chk("flushco_drained", dut.disc_q, 0);
    tick();

    // Reset in mid-operation abandons owed responses, then a stray data_ok flags an error
    issue(1, 3'd0, 1, 5'd29, 32'h600, 32'h0);
    reset = 1; tick(); reset = 0;
    chk("midrst_disc", dut.disc_q, 0);
    chk("midrst_allowin", ms_allowin, 1);
    resp(32'h3);
    chk("stray_err", ms_resp_err, 1);
    repeat (3) tick();
    chk("err_sticky", ms_resp_err, 1);
    reset = 1; tick(); reset = 0;
    chk("err_cleared", ms_resp_err, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_mo.md
MEM_STAGE_MO -- requirements
Module: mem_stage_mo

Interface
REQ-001 Parameter DEPTH, default 4: entry-queue depth; power of two, range 2..16.
REQ-002 Parameter XLEN, default 32: data width; only 32 is legal.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 es_to_ms_valid  in  1  EX offers one instruction.
REQ-006 ms_allowin  out  1  stage accepts an instruction this cycle.
REQ-007 es_is_mem  in  1  the instruction issued a data request; one data_ok is owed.
REQ-008 es_mem_op  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 STORE.
REQ-009 es_gr_we, es_dest, es_pc, es_alu_result, es_rt_value  in  1/5/32/32/32  instruction fields.
REQ-010 data_sram_data_ok, data_sram_rdata  in  1/32  in-order data response.
REQ-011 flush  in  1  exception or eret flush from WB.
REQ-012 ws_allowin  in  1  WB accepts an instruction.
REQ-013 ms_to_ws_valid  out  1  head instruction complete.
REQ-014 ms_gr_we, ms_dest, ms_pc, ms_result  out  1/5/32/32  head instruction fields.
REQ-015 ms_fwd_valid, ms_fwd_dest  out  1/5  forward entry: youngest valid entry with gr_we = 1 and result ready.
REQ-016 ms_fwd_result  out  32  value of the forward entry.
REQ-017 ms_fwd_stall  out  1  youngest valid gr_we entry is a load still awaiting data.
REQ-018 ms_resp_err  out  1  sticky: a data_ok arrived while nothing was owed.

Function
REQ-019 The block SHALL hold up to DEPTH in-order entries in a circular queue with head and tail pointers and an occupancy counter.
REQ-020 ms_allowin = !full.
- Dequeue in the same cycle SHALL NOT free a slot for enqueue.
REQ-021 Enqueue on es_to_ms_valid && ms_allowin.
- Entry ready = !es_is_mem.
- Result = es_alu_result.
REQ-022 data_ok SHALL complete the oldest entry with es_is_mem = 1 that is not yet ready.
- Set ready.
- Load ops store the aligned result; STORE keeps alu_result.
- Store completion SHALL require data_ok.
REQ-023 Alignment uses a = alu_result[1:0].
- LB/LBU select byte a, sign- or zero-extended.
- LH/LHU select halfword a[1], sign- or zero-extended.
- LW passes rdata.
- LWL merges rdata[8a+7:0] into the high bytes, keeping rt low bytes.
- LWR merges rdata[31:8a] into the low bytes, keeping rt high bytes.
REQ-024 Responses SHALL complete entries strictly in order.
- A data_ok in the enqueue cycle SHALL NOT complete the entry being enqueued.
REQ-025 ms_to_ws_valid = head valid && head ready.
- Dequeue on ms_to_ws_valid && ws_allowin.
- Latency for a non-mem instruction with an empty queue: 1 cycle.
REQ-026 On flush:
- All entries SHALL be invalidated.
- A discard counter SHALL load the number of owed, not-yet-received responses, counting a data_ok in the flush cycle as received.
- flush SHALL override enqueue in the same cycle.
REQ-027 While the discard counter is non-zero, each data_ok SHALL decrement it and SHALL be otherwise ignored.
REQ-028 ms_allowin SHALL stay high during discard; new entries SHALL only take responses after the counter reaches 0.
REQ-029 A data_ok with no owed entry and discard = 0 SHALL set ms_resp_err and change no other state.
REQ-030 The discard counter width SHALL be clog2(DEPTH+1).

Reset
REQ-031 During reset, SHALL hold these values:
- Queue empty; pointers, counters and discard counter 0.
- ms_allowin = 1.
- All other outputs 0, including ms_resp_err.
REQ-032 Reset in mid-operation SHALL abandon owed responses without a discard count.
- The system resets the bus concurrently.

Structure
REQ-033 Shared package mem_pkg SHALL hold:
- The mem_op encoding constants.
- An entry struct typedef: pc, dest, gr_we, is_mem, op, ready, alu_result, rt_value, result.
REQ-034 Byte/halfword/LWL/LWR alignment SHALL be a combinational sub-module ms_load_align(op, addr_lo, rdata, rt_value -> result).

Verification
REQ-035 LB at address 0x...3 with rdata 0x80FF_1234 -> ms_result 0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
REQ-036 LWL, a=1, rdata 0xAABB_CCDD, rt 0x1122_3344 -> 0xCCDD_3344. LWR, a=2, same inputs -> 0x1122_AABB.
REQ-037 DEPTH=4: 4 loads enqueued with no data_ok, then a 5th is offered:
- ms_allowin = 0.
- 4 data_ok pulses retire the loads in order with the matching results.
REQ-038 Flush with 3 owed responses:
- Discard counter = 3.
- 3 data_ok pulses are ignored.
- The next load enqueued takes the 4th data_ok.
REQ-039 Flush coincident with data_ok and with es_to_ms_valid, 2 owed:
- Discard counter = 1.
- The instruction is not enqueued.
REQ-040 data_ok on an idle stage -> ms_resp_err = 1 and stays 1 until reset.
